// File: rtl/adc_axil_pkg.sv
// Shared definitions for the ADC register-bank AXI-Lite read slave:
// response codes, read FSM states and byte-address to word-index decode.
package adc_axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_RESP    = 2'd2
    } rd_state_e;

    // Byte lanes within a word are irrelevant to a word-wide register read.
    function automatic logic [31:0] word_index(input logic [31:0] byte_addr);
        return {2'b00, byte_addr[31:2]};
    endfunction

endpackage

// File: rtl/adc_axil_rd_mux.sv
// Combinational word select over the flattened register bank, with a flag
// telling whether the requested index maps to an implemented register.
module adc_axil_rd_mux #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 8,
    parameter int IDX_W    = 6
) (
    input  logic [NUM_REGS*DATA_W-1:0] reg_rdata,
    input  logic [IDX_W-1:0]           idx,
    output logic [DATA_W-1:0]          word,
    output logic                       in_range
);

    // One extra bit so NUM_REGS == 2**IDX_W is still representable.
    localparam logic [IDX_W:0] NUM_REGS_L = (IDX_W + 1)'(NUM_REGS);

    logic [IDX_W:0] idx_ext;

    always_comb begin
        idx_ext  = {1'b0, idx};
        in_range = (idx_ext < NUM_REGS_L);
        word     = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (idx_ext == (IDX_W + 1)'(i)) begin
                word = reg_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/adc_axil_read_bank.sv
// AXI-Lite read-only slave over a bank of live ADC status registers, with
// per-register read-to-clear strobes and SLVERR for unimplemented words.
module adc_axil_read_bank
    import adc_axil_pkg::*;
#(
    parameter int                    DATA_W   = 32,
    parameter int                    ADDR_W   = 8,
    parameter int                    NUM_REGS = 8,
    parameter logic [NUM_REGS-1:0]   RC_MASK  = '0
) (
    input  logic                       ACLK,
    input  logic                       ARESETN,
    input  logic [ADDR_W-1:0]          ARADDR,
    input  logic                       ARVALID,
    output logic                       ARREADY,
    output logic [DATA_W-1:0]          RDATA,
    output logic [1:0]                 RRESP,
    output logic                       RVALID,
    input  logic                       RREADY,
    input  logic [NUM_REGS*DATA_W-1:0] reg_rdata,
    output logic [NUM_REGS-1:0]        rd_strobe
);

    localparam int IDX_W = ADDR_W - 2;

    rd_state_e         state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [1:0]        rresp_q, rresp_d;

    logic [31:0]       addr_ext;
    logic [31:0]       idx_full;
    logic              unused_idx_hi;
    logic [DATA_W-1:0] mux_word;
    logic              mux_in_range;
    logic              ar_hs;
    logic              r_hs;

    adc_axil_rd_mux #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W)
    ) u_rd_mux (
        .reg_rdata (reg_rdata),
        .idx       (idx_q),
        .word      (mux_word),
        .in_range  (mux_in_range)
    );

    always_comb begin
        addr_ext      = 32'(ARADDR);
        idx_full      = word_index(addr_ext);
        unused_idx_hi = ^idx_full[31:IDX_W];
        ar_hs         = ARVALID && (state_q == ST_IDLE);
        r_hs          = RREADY && (state_q == ST_RESP);
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (ar_hs) state_d = ST_CAPTURE;
            ST_CAPTURE: state_d = ST_RESP;
            ST_RESP:    if (r_hs) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // The strobe fires in the same cycle the word is sampled, so a clear it
    // triggers only lands after the value has already been captured.
    always_comb begin
        ARREADY   = (state_q == ST_IDLE);
        RVALID    = (state_q == ST_RESP);
        RDATA     = rdata_q;
        RRESP     = rresp_q;
        rd_strobe = '0;
        if ((state_q == ST_CAPTURE) && mux_in_range) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (RC_MASK[i] && (idx_q == IDX_W'(i))) begin
                    rd_strobe[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        idx_d   = idx_q;
        rdata_d = rdata_q;
        rresp_d = rresp_q;
        if (ar_hs) begin
            idx_d = idx_full[IDX_W-1:0];
        end
        if (state_q == ST_CAPTURE) begin
            rdata_d = mux_in_range ? mux_word : '0;
            rresp_d = mux_in_range ? RESP_OKAY : RESP_SLVERR;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            idx_q   <= '0;
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
        end else begin
            idx_q   <= idx_d;
            rdata_q <= rdata_d;
            rresp_q <= rresp_d;
        end
    end

endmodule

// File: tb/tb_adc_axil_read_bank.sv
// Directed plus randomized read traffic against a register-bank model that
// applies read-to-clear by rule, with immediate-assertion checks.
module tb_adc_axil_read_bank;

    localparam int         DW   = 32;
    localparam int         AW   = 8;
    localparam int         NR   = 8;
    localparam logic [7:0] RCM  = 8'h02;

    logic            ACLK;
    logic            ARESETN;
    logic [AW-1:0]   ARADDR;
    logic            ARVALID;
    logic            ARREADY;
    logic [DW-1:0]   RDATA;
    logic [1:0]      RRESP;
    logic            RVALID;
    logic            RREADY;
    logic [NR*DW-1:0] reg_rdata;
    logic [NR-1:0]   rd_strobe;

    logic [DW-1:0] regs [NR];
    logic [DW-1:0] model_regs [NR];
    logic [DW-1:0] exp_data;
    logic [1:0]    exp_resp;
    int            n_cmp;
    int            n_err;
    int            cyc;

    adc_axil_read_bank #(
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .NUM_REGS (NR),
        .RC_MASK  (RCM)
    ) dut (
        .ACLK      (ACLK),
        .ARESETN   (ARESETN),
        .ARADDR    (ARADDR),
        .ARVALID   (ARVALID),
        .ARREADY   (ARREADY),
        .RDATA     (RDATA),
        .RRESP     (RRESP),
        .RVALID    (RVALID),
        .RREADY    (RREADY),
        .reg_rdata (reg_rdata),
        .rd_strobe (rd_strobe)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    always_comb begin
        for (int i = 0; i < NR; i++) reg_rdata[i*DW +: DW] = regs[i];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; the emulated register bank clears any word whose
    // strobe was high during the cycle just ended.
    task automatic tick();
        logic [NR-1:0] s;
        s = rd_strobe;
        @(posedge ACLK);
        #1;
        cyc++;
        for (int i = 0; i < NR; i++) if (s[i]) regs[i] = '0;
    endtask

    task automatic start_read(input logic [7:0] addr, input bit hold, input logic [7:0] next_addr,
                              output int hs_cyc, output int waited);
        int idx;
        logic [7:0] es;
        idx     = int'(addr[7:2]);
        ARADDR  = addr;
        ARVALID = 1'b1;
        waited  = 0;
        while (!ARREADY && waited < 16) begin
            tick();
            waited++;
        end
        chk("ar_accept", 64'(ARREADY), 64'(1));
        hs_cyc = cyc;
        if (idx < NR) begin
            exp_data = model_regs[idx];
            exp_resp = 2'b00;
            es       = RCM[idx] ? (8'h01 << idx) : 8'h00;
            if (RCM[idx]) model_regs[idx] = '0;
        end else begin
            exp_data = '0;
            exp_resp = 2'b10;
            es       = 8'h00;
        end
        tick();
        if (hold) ARADDR = next_addr;
        else ARVALID = 1'b0;
        chk("cap_arready", 64'(ARREADY), 64'(0));
        chk("cap_rvalid", 64'(RVALID), 64'(0));
        chk("cap_strobe", 64'(rd_strobe), 64'(es));
        tick();
        chk("resp_rvalid", 64'(RVALID), 64'(1));
        chk("resp_latency", 64'(cyc - hs_cyc), 64'(2));
        chk("resp_rdata", 64'(RDATA), 64'(exp_data));
        chk("resp_rresp", 64'(RRESP), 64'(exp_resp));
        chk("resp_strobe", 64'(rd_strobe), 64'(0));
        chk("resp_arready", 64'(ARREADY), 64'(0));
    endtask

    task automatic finish_read(input int stall);
        RREADY = 1'b0;
        for (int k = 0; k < stall; k++) begin
            tick();
            chk("stall_rvalid", 64'(RVALID), 64'(1));
            chk("stall_rdata", 64'(RDATA), 64'(exp_data));
            chk("stall_rresp", 64'(RRESP), 64'(exp_resp));
            chk("stall_arready", 64'(ARREADY), 64'(0));
        end
        RREADY = 1'b1;
        tick();
        chk("done_rvalid", 64'(RVALID), 64'(0));
        chk("done_arready", 64'(ARREADY), 64'(1));
    endtask

    initial begin
        int hs0, hs1, hs2, w;
        logic [7:0] a;
        int r;
        logic [DW-1:0] v;
        n_cmp   = 0;
        n_err   = 0;
        cyc     = 0;
        ARESETN = 1'b0;
        ARVALID = 1'b0;
        ARADDR  = '0;
        RREADY  = 1'b1;
        for (int i = 0; i < NR; i++) begin
            regs[i]       = $urandom;
            model_regs[i] = regs[i];
        end
        regs[3]       = 32'hDEADBEEF;
        model_regs[3] = 32'hDEADBEEF;

        #12;
        chk("rst_arready", 64'(ARREADY), 64'(1));
        chk("rst_rvalid", 64'(RVALID), 64'(0));
        chk("rst_rdata", 64'(RDATA), 64'(0));
        chk("rst_rresp", 64'(RRESP), 64'(0));
        chk("rst_strobe", 64'(rd_strobe), 64'(0));
        @(negedge ACLK);
        ARESETN = 1'b1;

        // First request right after reset release, then the DEADBEEF read.
        start_read(8'h10, 1'b0, 8'h00, hs0, w);
        chk("first_wait", 64'(w), 64'(0));
        finish_read(0);
        start_read(8'h0C, 1'b0, 8'h00, hs0, w);
        finish_read(0);
        chk("idle_at_n3", 64'(cyc - hs0), 64'(3));

        // Out of range, then read-to-clear and a plain register.
        start_read(8'h20, 1'b0, 8'h00, hs0, w);
        finish_read(0);
        start_read(8'h04, 1'b0, 8'h00, hs0, w);
        finish_read(0);
        start_read(8'h08, 1'b0, 8'h00, hs0, w);
        finish_read(0);
        start_read(8'h05, 1'b0, 8'h00, hs0, w);
        finish_read(0);

        // Ten-cycle stall with a new request pending behind it.
        regs[2]       = $urandom;
        model_regs[2] = regs[2];
        start_read(8'h0C, 1'b0, 8'h00, hs0, w);
        ARVALID = 1'b1;
        ARADDR  = 8'h08;
        finish_read(10);
        hs1 = cyc;
        start_read(8'h08, 1'b0, 8'h00, hs2, w);
        chk("pend_accept_cyc", 64'(hs2), 64'(hs1));
        finish_read(0);

        // Reset pulse while a response is outstanding.
        start_read(8'h14, 1'b0, 8'h00, hs0, w);
        RREADY = 1'b0;
        #2;
        ARESETN = 1'b0;
        #1;
        chk("async_rvalid", 64'(RVALID), 64'(0));
        chk("async_arready", 64'(ARREADY), 64'(1));
        chk("async_rdata", 64'(RDATA), 64'(0));
        chk("async_strobe", 64'(rd_strobe), 64'(0));
        @(negedge ACLK);
        ARESETN = 1'b1;
        RREADY  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("post_rst_rvalid", 64'(RVALID), 64'(0));
        end
        start_read(8'h00, 1'b0, 8'h00, hs0, w);
        finish_read(0);

        // Back-to-back with ARVALID held high throughout.
        regs[1]       = $urandom;
        model_regs[1] = regs[1];
        start_read(8'h00, 1'b1, 8'h04, hs0, w);
        finish_read(0);
        start_read(8'h04, 1'b1, 8'h07, hs1, w);
        finish_read(0);
        regs[1]       = 32'h0BAD_F00D;
        model_regs[1] = 32'h0BAD_F00D;
        start_read(8'h07, 1'b0, 8'h00, hs2, w);
        finish_read(0);
        chk("b2b_gap1", 64'(hs1 - hs0), 64'(3));
        chk("b2b_gap2", 64'(hs2 - hs1), 64'(3));

        // Randomized traffic against the rule-based bank model.
        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                r             = int'($urandom_range(0, NR - 1));
                v             = $urandom;
                regs[r]       = v;
                model_regs[r] = v;
            end
            a = 8'($urandom_range(0, 47));
            start_read(a, 1'b0, 8'h00, hs0, w);
            finish_read(int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/adc_axil_read_bank.md
ADC_AXIL_READ_BANK -- requirements
Module: adc_axil_read_bank

Interface
Parameters:
REQ-001 DATA_W, default 32, sets the AXI read data width and the width of each register word.
REQ-002 ADDR_W, default 8, sets the ARADDR width; the byte address is decoded as a word index ARADDR[ADDR_W-1:2].
REQ-003 NUM_REGS, default 8, sets the number of readable registers; legal range is 1 to 2**(ADDR_W-2).
REQ-004 RC_MASK, default 0, NUM_REGS bits; bit i set marks register i as read-to-clear.

Ports (reset ARESETN, asynchronous, active-low; clock ACLK):
REQ-005 ACLK  in  1  AXI clock; all logic is rising-edge.
REQ-006 ARESETN  in  1  asynchronous active-low reset.
REQ-007 ARADDR  in  ADDR_W  read byte address.
REQ-008 ARVALID  in  1  address valid.
REQ-009 ARREADY  out  1  address accepted.
REQ-010 RDATA  out  DATA_W  read data.
REQ-011 RRESP  out  2  read response: OKAY=00, SLVERR=10.
REQ-012 RVALID  out  1  read data valid.
REQ-013 RREADY  in  1  master accepts the read data.
REQ-014 reg_rdata  in  NUM_REGS*DATA_W  live register values; word i occupies bits [i*DATA_W +: DATA_W].
REQ-015 rd_strobe  out  NUM_REGS  one-cycle pulse per accepted in-range read, for read-to-clear.

Function
REQ-016 The FSM SHALL have 3 states: IDLE, CAPTURE, RESP.
REQ-017 In IDLE, ARREADY SHALL be 1; in every other state it SHALL be 0.
REQ-018 IDLE->CAPTURE on ARVALID&ARREADY; the word index SHALL be latched in that same cycle.
- ARADDR is not sampled again after the handshake.
REQ-019 CAPTURE->RESP unconditionally, after 1 cycle.
- RDATA SHALL be registered from reg_rdata[index] during CAPTURE.
- RRESP SHALL be registered during CAPTURE.
REQ-020 RESP: RVALID SHALL be 1.
- RDATA and RRESP SHALL be held stable until RVALID&RREADY.
- On that handshake: RESP->IDLE.
REQ-021 Latency: AR handshake at cycle N gives RVALID=1 at cycle N+2.
- Minimum spacing between address handshakes SHALL be 3 cycles when RREADY is held at 1.
REQ-022 If index >= NUM_REGS: RRESP=SLVERR, RDATA=0, no rd_strobe bit asserted.
REQ-023 If index < NUM_REGS: RRESP=OKAY.
REQ-024 ARADDR[1:0] SHALL be ignored; there is no alignment error.
REQ-025 rd_strobe[i] SHALL pulse high for exactly the CAPTURE cycle when index==i, i is in range, and RC_MASK[i]=1; otherwise it SHALL stay 0.
REQ-026 RDATA SHALL reflect the reg_rdata value sampled in CAPTURE.
- A register clear caused by rd_strobe SHALL NOT corrupt the returned value.
REQ-027 If ARVALID is asserted while the FSM is in CAPTURE or RESP, it SHALL be left pending and accepted on the next IDLE cycle.
REQ-028 RREADY held at 0 SHALL stall indefinitely in RESP with no change to any output.

Reset
REQ-029 ARESETN low, asynchronously, SHALL force:
- state=IDLE, ARREADY=1;
- RVALID=0, RDATA=0, RRESP=OKAY;
- rd_strobe=0, latched index=0.
REQ-030 Reset asserted mid-transaction SHALL abort it; no response is issued after reset release.
REQ-031 After reset release, the first ARVALID SHALL be accepted in the first clock cycle.

Structure
REQ-032 Package adc_axil_pkg SHALL hold:
- the RESP_OKAY and RESP_SLVERR constants;
- the 3-state FSM enum typedef;
- the word-index extraction function.
REQ-033 Sub-module adc_axil_rd_mux SHALL implement the combinational NUM_REGS:1 word select with its in-range flag; the FSM and output registers stay in the top module.

Verification
REQ-034 NUM_REGS=8, reg word 3=32'hDEADBEEF, read 0x0C with RREADY=1:
- ARREADY handshake at cycle N;
- RVALID at N+2 with RDATA=DEADBEEF, RRESP=00;
- IDLE again at N+3.
REQ-035 Read 0x20 (index 8, out of range): RDATA=0, RRESP=10, rd_strobe=0.
REQ-036 RC_MASK=8'h02, read 0x04: rd_strobe=8'h02 for exactly 1 cycle; no strobe on a read of 0x08.
REQ-037 RREADY=0 for 10 cycles in RESP:
- RVALID, RDATA and RRESP stay constant and ARREADY=0;
- a new ARVALID is not accepted until after the R handshake.
REQ-038 ARESETN pulsed low during RESP:
- RVALID drops to 0 asynchronously and ARREADY=1;
- a following read of 0x00 completes normally.
REQ-039 Back-to-back reads of 0x00, 0x04, 0x07 (low bits ignored, so 0x07 is index 1) with ARVALID held:
- the 3 responses come in order with the correct data;
- handshakes are 3 cycles apart.
